// File: rtl/redun_to_bin.sv
// Redundant-coefficient to binary converter: resolves carries serially,
// WORDS_PER_CYCLE coefficients per clock, behind valid/ready handshakes.
module redun_to_bin #(
  parameter int unsigned NUM_COEF        = 10,
  parameter int unsigned WORD_BITS       = 8,
  parameter int unsigned COEF_BITS       = 9,
  parameter int unsigned WORDS_PER_CYCLE = 2
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_val,
  output logic                                 o_rdy,
  input  logic [NUM_COEF-1:0][COEF_BITS-1:0]   i_dat,
  output logic                                 o_val,
  input  logic                                 i_rdy,
  output logic [NUM_COEF*WORD_BITS-1:0]        o_dat,
  output logic                                 o_ovf
);

  localparam int unsigned CARRY_BITS = COEF_BITS - WORD_BITS + 1;
  localparam int unsigned N_STEPS    = NUM_COEF / WORDS_PER_CYCLE;
  localparam int unsigned SUM_BITS   = COEF_BITS + 1;
  localparam int unsigned OUT_BITS   = NUM_COEF * WORD_BITS;
  localparam int unsigned STEP_W     = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
  localparam int unsigned IDX_W      = (NUM_COEF > 1) ? $clog2(NUM_COEF) : 1;

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(N_STEPS - 1);

  if (COEF_BITS <= WORD_BITS) begin : g_bad_coef_bits
    $error("COEF_BITS must exceed WORD_BITS");
  end
  if ((NUM_COEF % WORDS_PER_CYCLE) != 0) begin : g_bad_words_per_cycle
    $error("WORDS_PER_CYCLE must divide NUM_COEF");
  end

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e                             state_q, state_d;
  logic [NUM_COEF-1:0][COEF_BITS-1:0] coef_q, coef_d;
  logic [CARRY_BITS-1:0]              carry_q, carry_d;
  logic [STEP_W-1:0]                  step_q, step_d;
  logic [OUT_BITS-1:0]                dat_q, dat_d;
  logic                               ovf_q, ovf_d;
  logic                               val_q, val_d;

  // Carry chain for the current step's group of coefficients.
  logic [OUT_BITS-1:0]   run_dat;
  logic [CARRY_BITS-1:0] run_carry;
  logic [CARRY_BITS-1:0] chain_carry;
  logic [SUM_BITS-1:0]   chain_sum;
  logic [IDX_W-1:0]      chain_idx;

  always_comb begin
    run_dat     = dat_q;
    chain_carry = carry_q;
    chain_sum   = '0;
    chain_idx   = '0;
    for (int j = 0; j < int'(WORDS_PER_CYCLE); j++) begin
      chain_idx = IDX_W'(int'(step_q) * int'(WORDS_PER_CYCLE) + j);
      chain_sum = SUM_BITS'(coef_q[chain_idx]) + SUM_BITS'(chain_carry);
      run_dat[int'(chain_idx) * int'(WORD_BITS) +: WORD_BITS] = chain_sum[WORD_BITS-1:0];
      chain_carry = chain_sum[SUM_BITS-1:WORD_BITS];
    end
    run_carry = chain_carry;
  end

  always_comb begin
    state_d = state_q;
    coef_d  = coef_q;
    carry_d = carry_q;
    step_d  = step_q;
    dat_d   = dat_q;
    ovf_d   = ovf_q;
    val_d   = val_q;
    unique case (state_q)
      StIdle: begin
        if (i_val) begin
          coef_d  = i_dat;
          carry_d = '0;
          step_d  = '0;
          dat_d   = '0;
          ovf_d   = 1'b0;
          state_d = StRun;
        end
      end
      StRun: begin
        dat_d   = run_dat;
        carry_d = run_carry;
        if (step_q == STEP_LAST) begin
          val_d   = 1'b1;
          ovf_d   = (run_carry != '0);
          state_d = StDone;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      StDone: begin
        if (i_rdy) begin
          val_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      coef_q  <= '0;
      carry_q <= '0;
      step_q  <= '0;
      dat_q   <= '0;
      ovf_q   <= 1'b0;
      val_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      coef_q  <= coef_d;
      carry_q <= carry_d;
      step_q  <= step_d;
      dat_q   <= dat_d;
      ovf_q   <= ovf_d;
      val_q   <= val_d;
    end
  end

  // Ready depends on state only, so i_rdy never reaches o_rdy combinationally.
  assign o_rdy = (state_q == StIdle);
  assign o_val = val_q;
  assign o_dat = dat_q;
  assign o_ovf = ovf_q;

endmodule

// File: tb/tb_redun_to_bin.sv
// Scoreboard bench for redun_to_bin: directed cases, backpressure, reset and a random sweep.
module tb_redun_to_bin;

  localparam int unsigned NUM_COEF        = 10;
  localparam int unsigned WORD_BITS       = 8;
  localparam int unsigned COEF_BITS       = 9;
  localparam int unsigned WORDS_PER_CYCLE = 2;
  localparam int unsigned N_STEPS         = NUM_COEF / WORDS_PER_CYCLE;
  localparam int unsigned OW              = NUM_COEF * WORD_BITS;
  localparam int unsigned AW              = OW + COEF_BITS;

  typedef logic [NUM_COEF-1:0][COEF_BITS-1:0] coef_t;
  typedef struct packed {
    logic [OW-1:0] dat;
    logic          ovf;
  } exp_t;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_val = 1'b0;
  logic          o_rdy;
  coef_t         i_dat = '0;
  logic          o_val;
  logic          i_rdy = 1'b1;
  logic [OW-1:0] o_dat;
  logic          o_ovf;

  redun_to_bin #(
    .NUM_COEF       (NUM_COEF),
    .WORD_BITS      (WORD_BITS),
    .COEF_BITS      (COEF_BITS),
    .WORDS_PER_CYCLE(WORDS_PER_CYCLE)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_val(i_val),
    .o_rdy(o_rdy),
    .i_dat(i_dat),
    .o_val(o_val),
    .i_rdy(i_rdy),
    .o_dat(o_dat),
    .o_ovf(o_ovf)
  );

  always #5 i_clk = ~i_clk;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   last_acc = 0;
  exp_t sb[$];
  int   acc_q[$];

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: full-width sum of weighted coefficients.
  function automatic void model(input coef_t d, output logic [OW-1:0] dat, output logic ovf);
    logic [AW-1:0] acc;
    acc = '0;
    for (int k = 0; k < int'(NUM_COEF); k++) begin
      acc = acc + (AW'(d[k]) << (k * int'(WORD_BITS)));
    end
    dat = acc[OW-1:0];
    ovf = |acc[AW-1:OW];
  endfunction

  // Output monitor: latency on each o_val rise, data on each transfer.
  logic val_prev = 1'b0;
  int   mon_acc;
  exp_t mon_exp;
  always @(negedge i_clk) begin
    if (i_rst) begin
      val_prev <= 1'b0;
    end else begin
      if (o_val && !val_prev) begin
        if (acc_q.size() == 0) begin
          check("spurious_val", 128'(o_val), 128'(0));
        end else begin
          mon_acc = acc_q.pop_front();
          check("latency", 128'(cyc - mon_acc), 128'(N_STEPS));
        end
      end
      if (o_val && i_rdy && sb.size() != 0) begin
        mon_exp = sb.pop_front();
        check("out_dat", 128'(o_dat), 128'(mon_exp.dat));
        check("out_ovf", 128'(o_ovf), 128'(mon_exp.ovf));
      end
      val_prev <= o_val;
    end
  end

  // Presents d until accepted; returns at accept edge + 1.
  task automatic send(input coef_t d, input logic [OW-1:0] ed, input logic eo, input bit hold);
    bit   done;
    exp_t e;
    done  = 1'b0;
    i_dat = d;
    i_val = 1'b1;
    for (int t = 0; t < 60 && !done; t++) begin
      @(negedge i_clk);
      if (o_rdy && !i_rst) done = 1'b1;
      @(posedge i_clk);
      #1;
    end
    if (!done) begin
      check("accept_timeout", 128'(0), 128'(1));
    end else begin
      e.dat = ed;
      e.ovf = eo;
      sb.push_back(e);
      acc_q.push_back(cyc);
      last_acc = cyc;
    end
    if (!hold) i_val = 1'b0;
  endtask

  task automatic drain();
    bit empty;
    empty = 1'b0;
    for (int t = 0; t < 60 && !empty; t++) begin
      @(posedge i_clk);
      #1;
      empty = (sb.size() == 0);
    end
    if (!empty) check("drain_timeout", 128'(0), 128'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    coef_t         d;
    logic [OW-1:0] md;
    logic          mo;
    int            e1;
    int            seen;
    bit            got;

    repeat (3) @(posedge i_clk);
    #1;
    check("rst_val", 128'(o_val), 128'(0));
    check("rst_rdy", 128'(o_rdy), 128'(1));
    check("rst_dat", 128'(o_dat), 128'(0));
    check("rst_ovf", 128'(o_ovf), 128'(0));
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;

    d    = '0;
    d[0] = 9'h1FF;
    send(d, 80'h1FF, 1'b0, 1'b0);
    drain();

    for (int k = 0; k < int'(NUM_COEF); k++) d[k] = 9'h1FF;
    send(d, 80'h0101_0101_0101_0101_00FF, 1'b1, 1'b0);
    drain();

    for (int k = 0; k < int'(NUM_COEF); k++) d[k] = 9'h100;
    send(d, 80'h0101_0101_0101_0101_0100, 1'b1, 1'b0);
    drain();

    // Backpressure with a stray i_val while DONE is held.
    d    = '0;
    d[0] = 9'h1F2;
    d[3] = 9'h1AB;
    d[9] = 9'h1C0;
    model(d, md, mo);
    i_rdy = 1'b0;
    send(d, md, mo, 1'b0);
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge i_clk);
      got = o_val;
    end
    check("bp_val_rise", 128'(got), 128'(1));
    for (int i = 0; i < 3; i++) begin
      @(posedge i_clk);
      #1;
      i_val = (i == 1);
      i_dat = '1;
      @(negedge i_clk);
      check("bp_val", 128'(o_val), 128'(1));
      check("bp_dat", 128'(o_dat), 128'(md));
      check("bp_ovf", 128'(o_ovf), 128'(mo));
      check("bp_rdy", 128'(o_rdy), 128'(0));
    end
    @(posedge i_clk);
    #1;
    i_val = 1'b0;
    i_rdy = 1'b1;
    @(posedge i_clk);
    #1;
    check("bp_release_rdy", 128'(o_rdy), 128'(1));
    check("bp_release_val", 128'(o_val), 128'(0));
    check("bp_drained", 128'(sb.size()), 128'(0));
    repeat (8) @(posedge i_clk);
    #1;

    // Reset two cycles after accept.
    for (int k = 0; k < int'(NUM_COEF); k++) d[k] = 9'h0F0;
    model(d, md, mo);
    send(d, md, mo, 1'b0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    check("midrst_val", 128'(o_val), 128'(0));
    check("midrst_rdy", 128'(o_rdy), 128'(1));
    check("midrst_dat", 128'(o_dat), 128'(0));
    check("midrst_ovf", 128'(o_ovf), 128'(0));
    i_rst = 1'b0;
    sb.delete();
    acc_q.delete();
    seen = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge i_clk);
      if (o_val) seen++;
    end
    check("midrst_no_val", 128'(seen), 128'(0));
    @(posedge i_clk);
    #1;
    d    = '0;
    d[1] = 9'h001;
    send(d, 80'h100, 1'b0, 1'b0);
    drain();

    // Back-to-back with i_val held high.
    for (int k = 0; k < int'(NUM_COEF); k++) d[k] = COEF_BITS'(k * 37 + 5);
    model(d, md, mo);
    send(d, md, mo, 1'b1);
    e1 = last_acc;
    for (int k = 0; k < int'(NUM_COEF); k++) d[k] = COEF_BITS'(511 - k * 13);
    model(d, md, mo);
    send(d, md, mo, 1'b1);
    check("b2b_gap", 128'(last_acc - e1), 128'(N_STEPS + 2));
    i_val = 1'b0;
    drain();

    // Random sweep, streamed back to back.
    for (int n = 0; n < 1000; n++) begin
      for (int k = 0; k < int'(NUM_COEF); k++) begin
        if ($urandom_range(0, 3) == 0) d[k] = 9'h1FF;
        else d[k] = COEF_BITS'($urandom_range(0, 511));
      end
      model(d, md, mo);
      send(d, md, mo, 1'b1);
    end
    i_val = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/redun_to_bin.md
# redun_to_bin

Converts a product in redundant coefficient form into plain binary, as emitted by the polynomial modular multiplier. It sits on that multiplier's output path wherever a normalised integer is needed, such as final result readout or comparison. Carry propagation runs serially, WORDS_PER_CYCLE coefficients per clock, so no full-width adder chain is built. Input and output both use a valid/ready handshake.

## Interface
Parameters:
- NUM_COEF, 10: number of input coefficients (2*I_WORD of the multiplier).
- WORD_BITS, 8: weight step between adjacent coefficients; also the output bits produced per coefficient.
- COEF_BITS, 9: width of each redundant coefficient; must exceed WORD_BITS.
- WORDS_PER_CYCLE, 2: coefficients resolved per RUN cycle; must divide NUM_COEF.
- Derived: CARRY_BITS = COEF_BITS-WORD_BITS+1; N_STEPS = NUM_COEF/WORDS_PER_CYCLE.

Ports:
- i_clk, in, 1: clock.
- i_rst, in, 1: reset, synchronous, active-high.
- i_val, in, 1: input valid.
- o_rdy, out, 1: input ready; high only in IDLE.
- i_dat, in, [NUM_COEF-1:0][COEF_BITS-1:0]: redundant value = Σ i_dat[k]·2^(k·WORD_BITS).
- o_val, out, 1: result valid.
- i_rdy, in, 1: downstream ready.
- o_dat, out, NUM_COEF*WORD_BITS: binary result, truncated to the output width.
- o_ovf, out, 1: final carry-out is nonzero, meaning the value did not fit in o_dat.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: o_rdy=1. When i_val&o_rdy is true, capture i_dat and clear the carry, step counter and o_dat, then go to RUN.
- RUN: each cycle processes coefficients k = step·WORDS_PER_CYCLE .. +WORDS_PER_CYCLE-1, in ascending order, chained combinationally.
  - Per coefficient: s = coef[k] + carry, computed at width COEF_BITS+1.
  - o_dat[k·WORD_BITS +: WORD_BITS] = s[WORD_BITS-1:0].
  - carry = s >> WORD_BITS; this fits in CARRY_BITS (max 2 at the defaults).
- Step counter: counts 0..N_STEPS-1. On the last step go to DONE, register o_val=1, and register o_ovf = (final carry != 0).
- DONE: hold o_val, o_dat and o_ovf stable until i_rdy=1. On i_val-independent i_rdy=1 (o_val&i_rdy), clear o_val and go to IDLE.
- o_rdy is 0 in RUN and DONE. i_val is ignored there, and the upstream source must hold its data until accepted.
- There is no combinational path from i_rdy to o_rdy.
- Unused high bits of o_dat are never written beyond NUM_COEF words. Any excess is reported only via o_ovf.

## Timing
- Reset values: o_val=0, o_rdy=1 (IDLE), o_dat=0, o_ovf=0. Internal carry and counter are 0.
- Latency: accept edge E; RUN covers edges E+1..E+N_STEPS; o_val is high after edge E+N_STEPS. At the defaults that is 5 cycles.
- Throughput: one conversion per N_STEPS+2 cycles when i_rdy=1 and i_val is held high. The next accept occurs on the first cycle back in IDLE.
- Reset in RUN or DONE: the next state is IDLE, all outputs take their reset values, and the in-flight data is discarded with no o_val pulse.
- o_dat is partially updated during RUN. Its value is defined only while o_val=1.

## Test plan
Defaults for all scenarios: NUM_COEF=10, WORD_BITS=8, COEF_BITS=9, WORDS_PER_CYCLE=2.
- Single coefficient: coef[0]=0x1FF, rest 0, i_rdy=1 -> o_val high 5 cycles after accept; o_dat=80'h1FF; o_ovf=0.
- All coefficients 0x1FF -> o_dat=80'h0101_0101_0101_0101_00FF; o_ovf=1 (final carry 2).
- All coefficients 0x100 -> o_dat=80'h0101_0101_0101_0101_0100; o_ovf=1.
- Backpressure: i_rdy=0 for 3 cycles after o_val rises, with a new i_val pulsed meanwhile -> o_val, o_dat and o_ovf held stable; o_rdy=0; the new input is not taken. Raising i_rdy returns to IDLE next cycle.
- Reset mid-RUN: assert i_rst 2 cycles after accept -> outputs reset next cycle; no o_val; the next input (coef[1]=0x001, rest 0) converts to 80'h100.
- Back-to-back: i_val held high with two inputs and i_rdy=1 -> accepts exactly 7 cycles apart; both results correct against a reference model, which is also run as a random sweep of 1000 vectors.
